// File: rtl/hist_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hist_ctrl_pkg
// Shared definitions for the histogram frame controller.
// Contents:
//   state_e            - 3-bit sequencer state encoding
//   BIN_COUNT / BIN_W  - number of histogram bins and bin-index width
//   DEFAULT_*          - default frame geometry, bin width and watchdog limit
// ----------------------------------------------------------------------------
package hist_ctrl_pkg;

   localparam int BIN_COUNT         = 256;
   localparam int BIN_W             = 8;
   localparam int DEFAULT_WORD_SIZE = 20;
   localparam int DEFAULT_PIXELS    = 384000;  // 800 x 480
   localparam int DEFAULT_TIMEOUT   = 1024;

   typedef enum logic [2:0] {
      S_CLEAR     = 3'd0,
      S_IDLE      = 3'd1,
      S_ACCUM     = 3'd2,
      S_DRAIN     = 3'd3,
      S_CUM_START = 3'd4,
      S_CUM_WAIT  = 3'd5,
      S_CUM_ACK   = 3'd6
   } state_e;

endpackage

// File: rtl/histogram_frame_controller_if.sv
// ----------------------------------------------------------------------------
// histogram_frame_controller_if
// Histogram RAM port plus the cumulative-histogram block handshake.
//   oHistRdAddr     - RAM read address (1-cycle read latency)
//   iHistQ          - RAM read data
//   oHistWrAddr     - RAM write address
//   oHistWrData     - RAM write data
//   oHistWE         - RAM write enable
//   iCumAddrInHist  - read address requested by the cumulative block
//   oCumStart       - cumulative block start pulse
//   oCumRestart     - cumulative block restart / acknowledge
//   iCumDone        - cumulative block done
//   iCumThreshold   - threshold computed by the cumulative block
// Modports: master = frame controller, slave = RAM + cumulative block.
// ----------------------------------------------------------------------------
interface histogram_frame_controller_if
   import hist_ctrl_pkg::*;
#(
   parameter int WORD_SIZE = DEFAULT_WORD_SIZE
);

   logic [BIN_W-1:0]     oHistRdAddr;
   logic [WORD_SIZE-1:0] iHistQ;
   logic [BIN_W-1:0]     oHistWrAddr;
   logic [WORD_SIZE-1:0] oHistWrData;
   logic                 oHistWE;
   logic [BIN_W-1:0]     iCumAddrInHist;
   logic                 oCumStart;
   logic                 oCumRestart;
   logic                 iCumDone;
   logic [BIN_W-1:0]     iCumThreshold;

   modport master (
      output oHistRdAddr, oHistWrAddr, oHistWrData, oHistWE, oCumStart, oCumRestart,
      input  iHistQ, iCumAddrInHist, iCumDone, iCumThreshold
   );

   modport slave (
      input  oHistRdAddr, oHistWrAddr, oHistWrData, oHistWE, oCumStart, oCumRestart,
      output iHistQ, iCumAddrInHist, iCumDone, iCumThreshold
   );

endinterface

// File: rtl/hist_rmw_pipe.sv
// ----------------------------------------------------------------------------
// hist_rmw_pipe
// Two-stage read-modify-write bin incrementer for a RAM with 1-cycle read
// latency. Stage 0 captures the bin whose read was issued this cycle; stage 1
// adds one (saturating) to the returned count and issues the write. The write
// just issued is kept one more cycle so a read that raced it is corrected.
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_valid     - a read for i_bin was issued this cycle
//   i_bin       - bin index being read
//   i_q         - RAM read data for the previous cycle's address
//   o_we        - write enable (stage 1)
//   o_addr      - write address (0 when idle)
//   o_data      - incremented count (0 when idle)
// ----------------------------------------------------------------------------
module hist_rmw_pipe
   import hist_ctrl_pkg::*;
#(
   parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_valid,
   input  logic [BIN_W-1:0]     i_bin,
   input  logic [WORD_SIZE-1:0] i_q,
   output logic                 o_we,
   output logic [BIN_W-1:0]     o_addr,
   output logic [WORD_SIZE-1:0] o_data
);

   logic                 v1_q, v1_d;
   logic [BIN_W-1:0]     bin1_q, bin1_d;
   logic                 v2_q, v2_d;
   logic [BIN_W-1:0]     bin2_q, bin2_d;
   logic [WORD_SIZE-1:0] wdata2_q, wdata2_d;
   logic [WORD_SIZE-1:0] base;
   logic [WORD_SIZE-1:0] inc;

   always_comb begin
      // NOTE: every variable gets a value before any branch so no latch is inferred.
      v1_d   = i_valid;
      bin1_d = i_bin;
      // The RAM read for bin1 was sampled on the same edge that committed the
      // previous write, so an equal bin must take the count from that write.
      base = (v2_q && (bin2_q == bin1_q)) ? wdata2_q : i_q;
      inc  = (base == '1) ? base : base + 1'b1;
      v2_d     = v1_q;
      bin2_d   = bin1_q;
      wdata2_d = inc;
      o_we   = v1_q;
      o_addr = v1_q ? bin1_q : '0;
      o_data = v1_q ? inc : '0;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q     <= 1'b0;
         bin1_q   <= '0;
         v2_q     <= 1'b0;
         bin2_q   <= '0;
         wdata2_q <= '0;
      end else begin
         v1_q     <= v1_d;
         bin1_q   <= bin1_d;
         v2_q     <= v2_d;
         bin2_q   <= bin2_d;
         wdata2_q <= wdata2_d;
      end
   end

endmodule

// File: rtl/histogram_frame_controller.sv
// ----------------------------------------------------------------------------
// histogram_frame_controller
// Per-frame sequencer for the threshold path: clears the 256-bin histogram RAM,
// accumulates an 8-bit pixel stream into it, runs the cumulative-histogram
// block, latches its threshold and acknowledges it, then clears again.
// Ports:
//   iClk, iRst_n      - clock, asynchronous active-low reset
//   iFrameStart       - frame start pulse (accepted only in IDLE)
//   iPixelValid/iPixel- pixel stream; pixel value is the bin index
//   oReady            - high while IDLE
//   hist_bus          - histogram RAM port and cumulative block handshake
//   oThreshold        - latched threshold
//   oThresholdValid   - one-cycle pulse when oThreshold updates
//   oFrameDropped     - sticky: a frame start arrived while busy
//   oError            - sticky watchdog error
// Build option: define HIST_CTRL_WATCHDOG_EN to enable the CUM_WAIT watchdog;
// without it CUM_WAIT waits indefinitely and oError stays 0.
// ----------------------------------------------------------------------------
module histogram_frame_controller
   import hist_ctrl_pkg::*;
#(
   parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
   parameter int PIXELS    = DEFAULT_PIXELS,
   parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
   input  logic                         iClk,
   input  logic                         iRst_n,
   input  logic                         iFrameStart,
   input  logic                         iPixelValid,
   input  logic [BIN_W-1:0]             iPixel,
   output logic                         oReady,
   histogram_frame_controller_if.master hist_bus,
   output logic [BIN_W-1:0]             oThreshold,
   output logic                         oThresholdValid,
   output logic                         oFrameDropped,
   output logic                         oError
);

   localparam int CNT_W = $clog2(PIXELS + 1);
   localparam int CLR_W = $clog2(BIN_COUNT + 1);
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     pix_cnt_q, pix_cnt_d;
   logic [CLR_W-1:0]     clr_cnt_q, clr_cnt_d;
   logic                 clr_we_q, clr_we_d;
   logic [BIN_W-1:0]     clr_addr_q, clr_addr_d;
   logic                 ready_q, ready_d;
   logic                 cum_start_q, cum_start_d;
   logic                 cum_restart_q, cum_restart_d;
   logic [BIN_W-1:0]     thr_q, thr_d;
   logic                 thr_valid_q, thr_valid_d;
   logic                 dropped_q, dropped_d;
   logic                 error_q, error_d;
   logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
   logic                 wd_expire;

   logic                 accept;
   logic                 rmw_we;
   logic [BIN_W-1:0]     rmw_addr;
   logic [WORD_SIZE-1:0] rmw_data;
   logic [BIN_W-1:0]     rd_addr;

   assign accept = (state_q == S_ACCUM) && iPixelValid;

   hist_rmw_pipe #(
      .WORD_SIZE (WORD_SIZE)
   ) u_rmw (
      .clk     (iClk),
      .rst_n   (iRst_n),
      .i_valid (accept),
      .i_bin   (iPixel),
      .i_q     (hist_bus.iHistQ),
      .o_we    (rmw_we),
      .o_addr  (rmw_addr),
      .o_data  (rmw_data)
   );

`ifdef HIST_CTRL_WATCHDOG_EN
   assign wd_expire = (wd_cnt_q == WD_W'(TIMEOUT - 1));
`else
   assign wd_expire = 1'b0;
`endif

   // The cumulative block owns the read port from its start until it is
   // acknowledged; accumulation owns it only while pixels can arrive.
   always_comb begin
      rd_addr = '0;
      if (state_q inside {S_CUM_START, S_CUM_WAIT, S_CUM_ACK}) begin
         rd_addr = hist_bus.iCumAddrInHist;
      end else if (state_q == S_ACCUM) begin
         rd_addr = iPixel;
      end
   end

   // Clear writes and RMW writes never overlap: RMW writes only follow ACCUM.
   assign hist_bus.oHistRdAddr = rd_addr;
   assign hist_bus.oHistWE     = clr_we_q | rmw_we;
   assign hist_bus.oHistWrAddr = clr_we_q ? clr_addr_q : rmw_addr;
   assign hist_bus.oHistWrData = clr_we_q ? '0 : rmw_data;
   assign hist_bus.oCumStart   = cum_start_q;
   assign hist_bus.oCumRestart = cum_restart_q;

   assign oReady          = ready_q;
   assign oThreshold      = thr_q;
   assign oThresholdValid = thr_valid_q;
   assign oFrameDropped   = dropped_q;
   assign oError          = error_q;

   always_comb begin
      state_d       = state_q;
      pix_cnt_d     = pix_cnt_q;
      clr_cnt_d     = clr_cnt_q;
      clr_we_d      = 1'b0;
      clr_addr_d    = clr_addr_q;
      cum_start_d   = 1'b0;
      cum_restart_d = 1'b0;
      thr_d         = thr_q;
      thr_valid_d   = 1'b0;
      dropped_d     = dropped_q;
      error_d       = error_q;
      wd_cnt_d      = '0;

      if (iFrameStart && (state_q != S_IDLE)) begin
         dropped_d = 1'b1;
      end

      unique case (state_q)
         // NOTE: RAM contents have no reset; the sequencer zeroes every bin
         // itself after reset and after each frame.
         S_CLEAR: begin
            if (clr_cnt_q == CLR_W'(BIN_COUNT)) begin
               clr_cnt_d = '0;
               state_d   = S_IDLE;
            end else begin
               clr_we_d   = 1'b1;
               clr_addr_d = clr_cnt_q[BIN_W-1:0];
               clr_cnt_d  = clr_cnt_q + 1'b1;
            end
         end
         S_IDLE: begin
            if (iFrameStart) begin
               pix_cnt_d = '0;
               dropped_d = 1'b0;
               state_d   = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (accept) begin
               pix_cnt_d = pix_cnt_q + 1'b1;
               if (pix_cnt_q == CNT_W'(PIXELS - 1)) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // Last RMW write is on the bus this cycle.
            cum_start_d = 1'b1;
            state_d     = S_CUM_START;
         end
         S_CUM_START: begin
            state_d = S_CUM_WAIT;
         end
         S_CUM_WAIT: begin
            if (hist_bus.iCumDone) begin
               thr_d         = hist_bus.iCumThreshold;
               thr_valid_d   = 1'b1;
               cum_restart_d = 1'b1;
               state_d       = S_CUM_ACK;
            end else if (wd_expire) begin
               error_d       = 1'b1;
               cum_restart_d = 1'b1;
               state_d       = S_CLEAR;
            end else begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
         end
         S_CUM_ACK: begin
            if (hist_bus.iCumDone) begin
               cum_restart_d = 1'b1;
            end else begin
               state_d = S_CLEAR;
            end
         end
         default: begin
            state_d = S_CLEAR;
         end
      endcase

      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q       <= S_CLEAR;
         pix_cnt_q     <= '0;
         clr_cnt_q     <= '0;
         clr_we_q      <= 1'b0;
         clr_addr_q    <= '0;
         ready_q       <= 1'b0;
         cum_start_q   <= 1'b0;
         cum_restart_q <= 1'b0;
         thr_q         <= '0;
         thr_valid_q   <= 1'b0;
         dropped_q     <= 1'b0;
         error_q       <= 1'b0;
         wd_cnt_q      <= '0;
      end else begin
         state_q       <= state_d;
         pix_cnt_q     <= pix_cnt_d;
         clr_cnt_q     <= clr_cnt_d;
         clr_we_q      <= clr_we_d;
         clr_addr_q    <= clr_addr_d;
         ready_q       <= ready_d;
         cum_start_q   <= cum_start_d;
         cum_restart_q <= cum_restart_d;
         thr_q         <= thr_d;
         thr_valid_q   <= thr_valid_d;
         dropped_q     <= dropped_d;
         error_q       <= error_d;
         wd_cnt_q      <= wd_cnt_d;
      end
   end

endmodule

// File: tb/tb_histogram_frame_controller.sv
// ----------------------------------------------------------------------------
// tb_histogram_frame_controller
// Directed bench for histogram_frame_controller with a 16-pixel frame. A
// behavioural 256-entry RAM (1-cycle read latency, read-first) sits on the
// histogram port; the cumulative block is driven directly from the stimulus.
// ----------------------------------------------------------------------------
module tb_histogram_frame_controller;
   import hist_ctrl_pkg::*;

   localparam int WS   = 20;
   localparam int NPIX = 16;
   localparam int TMO  = 1024;

   logic         clk;
   logic         rst_n;
   logic         frame_start;
   logic         pixel_valid;
   logic [7:0]   pixel;
   logic         ready;
   logic [7:0]   thr;
   logic         thr_valid;
   logic         dropped;
   logic         error;
   logic         fill;

   logic [WS-1:0] mem [0:255];

   int n_tests;
   int n_fail;

   histogram_frame_controller_if #(.WORD_SIZE(WS)) hbus ();

   histogram_frame_controller #(
      .WORD_SIZE (WS),
      .PIXELS    (NPIX),
      .TIMEOUT   (TMO)
   ) dut (
      .iClk            (clk),
      .iRst_n          (rst_n),
      .iFrameStart     (frame_start),
      .iPixelValid     (pixel_valid),
      .iPixel          (pixel),
      .oReady          (ready),
      .hist_bus        (hbus),
      .oThreshold      (thr),
      .oThresholdValid (thr_valid),
      .oFrameDropped   (dropped),
      .oError          (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Histogram RAM model; fill preloads garbage so clearing is observable.
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 256; i++) mem[i] <= 20'hABCDE;
      end else if (hbus.oHistWE) begin
         mem[hbus.oHistWrAddr] <= hbus.oHistWrData;
      end
      hbus.iHistQ <= mem[hbus.oHistRdAddr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int sum_bins();
      int s = 0;
      for (int i = 0; i < 256; i++) s += int'(mem[i]);
      return s;
   endfunction

   task automatic wait_ready(input int max_cyc);
      int n = 0;
      while (!ready && n < max_cyc) begin
         step();
         n++;
      end
      check("ready_wait", ready, 1);
   endtask

   // Called right after reset release; edge c presents clear write c-1.
   // With inject, frame starts are driven into cycles 10 and 256 (last write).
   task automatic check_clear_sequence(input bit inject);
      int bad = 0;
      logic r256 = 1'b0;
      logic r257 = 1'b0;
      for (int c = 1; c <= 257; c++) begin
         step();
         if (c <= 256) begin
            if (!hbus.oHistWE || hbus.oHistWrAddr != 8'(c - 1) || hbus.oHistWrData != '0) bad++;
         end else if (hbus.oHistWE) begin
            bad++;
         end
         if (c == 256) r256 = ready;
         if (c == 257) r257 = ready;
         frame_start = inject && (c == 10 || c == 256);
      end
      check("clr_bad_writes", bad, 0);
      check("ready_at_256", r256, 0);
      check("ready_at_257", r257, 1);
      check("clr_ram_zero", sum_bins(), 0);
      step();
      check("still_idle_after_late_start", ready, 1);
   endtask

   task automatic start_frame();
      wait_ready(400);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("start_leaves_idle", ready, 0);
      check("start_clears_dropped", dropped, 0);
   endtask

   task automatic send_pixel(input logic [7:0] v, input int gap, input bit chk_addr);
      pixel_valid = 1'b1;
      pixel       = v;
      if (chk_addr) begin
         #1;
         check("rd_addr_accum", hbus.oHistRdAddr, v);
      end
      step();
      pixel_valid = 1'b0;
      repeat (gap) step();
   endtask

   // Called in CUM_WAIT.
   task automatic cum_handshake(input logic [7:0] t);
      hbus.iCumThreshold = t;
      hbus.iCumDone      = 1'b1;
      step();
      check("thr_latched", thr, t);
      check("thr_valid_pulse", thr_valid, 1);
      check("restart_on_done", hbus.oCumRestart, 1);
      step();
      check("thr_valid_one_cycle", thr_valid, 0);
      check("restart_held_1", hbus.oCumRestart, 1);
      step();
      check("restart_held_2", hbus.oCumRestart, 1);
      hbus.iCumDone = 1'b0;
      step();
      check("restart_drops", hbus.oCumRestart, 0);
      check("clear_entry_no_we", hbus.oHistWE, 0);
      step();
      check("clear_first_we", hbus.oHistWE, 1);
      check("clear_first_addr", hbus.oHistWrAddr, 0);
      check("thr_kept", thr, t);
   endtask

   logic [7:0] f2_pix [16];
   int         f2_gap [16];

   initial begin
      int pulses;
      int first;
      int k;

      n_tests = 0;
      n_fail  = 0;
      rst_n = 1'b0;
      frame_start = 1'b0;
      pixel_valid = 1'b0;
      pixel = '0;
      fill = 1'b1;
      hbus.iCumAddrInHist = '0;
      hbus.iCumDone = 1'b0;
      hbus.iCumThreshold = '0;
      f2_pix = '{8'd3, 8'd3, 8'd5, 8'd3, 8'd9, 8'd9, 8'd9, 8'd200,
                 8'd200, 8'd0, 8'd255, 8'd255, 8'd255, 8'd9, 8'd3, 8'd0};
      f2_gap = '{1, 0, 2, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};

      repeat (3) step();
      fill = 1'b0;
      check("rst_ready", ready, 0);
      check("rst_we", hbus.oHistWE, 0);
      check("rst_wr_addr", hbus.oHistWrAddr, 0);
      check("rst_rd_addr", hbus.oHistRdAddr, 0);
      check("rst_cum_start", hbus.oCumStart, 0);
      check("rst_cum_restart", hbus.oCumRestart, 0);
      check("rst_thr", thr, 0);
      check("rst_thr_valid", thr_valid, 0);
      check("rst_dropped", dropped, 0);
      check("rst_error", error, 0);

      rst_n = 1'b1;
      check_clear_sequence(1'b1);
      check("drop_in_clear", dropped, 1);

      // Frame 1: sixteen back-to-back pixels of value 7.
      start_frame();
      for (int i = 0; i < NPIX; i++) send_pixel(8'd7, 0, i == 0);
      check("f1_cum_start_early", hbus.oCumStart, 0);
      step();
      check("f1_cum_start", hbus.oCumStart, 1);
      check("f1_no_we_in_cum_start", hbus.oHistWE, 0);
      check("f1_bin7", mem[7], 16);
      check("f1_other_bins", sum_bins() - int'(mem[7]), 0);
      step();
      check("f1_cum_start_once", hbus.oCumStart, 0);
      hbus.iCumAddrInHist = 8'h5A;
      #1;
      check("rd_addr_cum_mux", hbus.oHistRdAddr, 8'h5A);
      cum_handshake(8'd128);

      // Frame 2: mixed bins with gaps; a frame start during ACCUM is dropped.
      start_frame();
      for (int i = 0; i < NPIX; i++) begin
         pixel_valid = 1'b1;
         pixel = f2_pix[i];
         step();
         pixel_valid = 1'b0;
         for (int g = 0; g < f2_gap[i]; g++) begin
            frame_start = (i == 6);
            step();
            frame_start = 1'b0;
         end
      end
      check("drop_in_accum", dropped, 1);
      pulses = 0;
      first  = -1;
      for (k = 1; k <= 6; k++) begin
         step();
         if (hbus.oCumStart) begin
            pulses++;
            if (first < 0) first = k;
         end
      end
      check("f2_cum_start_pulses", pulses, 1);
      check("f2_cum_start_edge", first, 1);
      check("f2_bin3", mem[3], 4);
      check("f2_bin5", mem[5], 1);
      check("f2_bin9", mem[9], 4);
      check("f2_bin200", mem[200], 2);
      check("f2_bin0", mem[0], 2);
      check("f2_bin255", mem[255], 3);
      check("f2_total", sum_bins(), 16);

`ifdef HIST_CTRL_WATCHDOG_EN
      // Edge 2 entered CUM_WAIT; the 1024th waiting edge is edge 1026.
      while (!error && k < 1200) begin
         step();
         k++;
      end
      check("wd_error_edge", k, 1026);
      check("wd_restart_pulse", hbus.oCumRestart, 1);
      check("wd_thr_unchanged", thr, 128);
      check("wd_no_thr_valid", thr_valid, 0);
      step();
      check("wd_restart_one_cycle", hbus.oCumRestart, 0);
      check("wd_error_sticky", error, 1);
      wait_ready(400);
      check("wd_error_still", error, 1);
`else
      repeat (1100) step();
      check("nowd_still_waiting", ready, 0);
      check("nowd_no_restart", hbus.oCumRestart, 0);
      check("nowd_error_zero", error, 0);
      cum_handshake(8'd77);
`endif

      // Frame 3: reset in the middle of accumulation.
      start_frame();
      for (int i = 0; i < 5; i++) send_pixel(8'd42, 0, 1'b0);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("f3_dropped", dropped, 1);
      pixel_valid = 1'b1;
      pixel = 8'd42;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", ready, 0);
      check("mid_rst_we", hbus.oHistWE, 0);
      check("mid_rst_wr_data", hbus.oHistWrData, 0);
      check("mid_rst_rd_addr", hbus.oHistRdAddr, 0);
      check("mid_rst_thr", thr, 0);
      check("mid_rst_dropped", dropped, 0);
      check("mid_rst_error", error, 0);
      pixel_valid = 1'b0;
      pixel = '0;
      step();
      rst_n = 1'b1;
      check_clear_sequence(1'b0);
      check("mid_rst_bin42", mem[42], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
